wr_ctrl: RTL and testbench

WR_CTRL -- requirements
Module: wr_ctrl

---
 rtl/wr_ctrl_if.sv | 29 ++
 rtl/wr_ctrl.sv | 112 +++++++++++
 tb/tb_wr_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/wr_ctrl_if.sv
// Bundle of the start/done handshake, FIFO read port and Avalon-MM write host
// signals that connect wr_ctrl to its environment.
interface wr_ctrl_if;
   logic        wr_ctrl;
   logic [31:0] dst_begin;
   logic [31:0] dst_end;
   logic        wr_ctrl_rdy;
   logic [31:0] fifo_out;
   logic        fifo_empty;
   logic        rd_from_fifo;
   logic [31:0] address;
   logic [31:0] writedata;
   logic        write;
   logic [15:0] burstcount;
   logic [3:0]  byteenable;
   logic        waitrequest;

   modport master (
      input  wr_ctrl, dst_begin, dst_end, fifo_out, fifo_empty, waitrequest,
      output wr_ctrl_rdy, rd_from_fifo, address, writedata, write,
             burstcount, byteenable
   );

   modport slave (
      output wr_ctrl, dst_begin, dst_end, fifo_out, fifo_empty, waitrequest,
      input  wr_ctrl_rdy, rd_from_fifo, address, writedata, write,
             burstcount, byteenable
   );
endinterface

// File: rtl/wr_ctrl.sv
// Avalon-MM burst write controller: drains a show-ahead FIFO into a
// destination byte range [dst_begin, dst_end) using bursts of up to MAX_BURST
// words, then pulses wr_ctrl_rdy once the transfer is complete.
module wr_ctrl #(
   parameter int MAX_BURST = 16
) (
   input  logic clk,
   input  logic reset,
   wr_ctrl_if.master bus
);

   localparam int CNT_W = 9;

   typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

   state_t           state_q;
   logic [31:0]      addr_q;
   logic [15:0]      bcnt_q;
   logic [CNT_W-1:0] beats_q;
   logic [16:0]      words_q;
   logic [1:0]       lenmod_q;
   logic             rdy_q;

   logic [31:0]      begin_al_d;
   logic [15:0]      len_d;
   logic [16:0]      words_d;
   logic             last_beat;
   logic             accept;

   // Burst length for the next burst: the remaining words, capped at MAX_BURST.
   function automatic logic [15:0] burst_len(input logic [16:0] w);
      if (w > 17'(MAX_BURST)) return 16'(MAX_BURST);
      else                    return w[15:0];
   endfunction

   // Byte enables for the final word of a transfer, from len % 4.
   function automatic logic [3:0] final_be(input logic [1:0] m);
      case (m)
         2'd1:    return 4'b0001;
         2'd2:    return 4'b0011;
         2'd3:    return 4'b0111;
         default: return 4'b1111;
      endcase
   endfunction

   // Start-time length arithmetic; only the low 16 bits of the difference
   // count, so a wrapped range yields the modular length.
   assign begin_al_d = {bus.dst_begin[31:2], 2'b00};
   assign len_d      = bus.dst_end[15:0] - begin_al_d[15:0];
   assign words_d    = ({1'b0, len_d} + 17'd3) >> 2;

   assign last_beat  = (words_q == 17'd1);
   assign accept     = bus.write && !bus.waitrequest;

   // Beats are data-driven: write follows FIFO occupancy while in BURST.
   assign bus.write        = (state_q == BURST) && !bus.fifo_empty;
   assign bus.rd_from_fifo = accept;
   assign bus.writedata    = bus.fifo_out;
   assign bus.address      = addr_q;
   assign bus.burstcount   = bcnt_q;
   assign bus.byteenable   = (state_q == BURST && last_beat) ? final_be(lenmod_q) : 4'b1111;
   assign bus.wr_ctrl_rdy  = rdy_q;

   // Transfer FSM: latch the request, step through bursts, then pulse ready.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         bcnt_q   <= '0;
         beats_q  <= '0;
         words_q  <= '0;
         lenmod_q <= '0;
         rdy_q    <= 1'b0;
      end else begin
         rdy_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.wr_ctrl) begin
                  addr_q   <= begin_al_d;
                  lenmod_q <= len_d[1:0];
                  words_q  <= words_d;
                  bcnt_q   <= burst_len(words_d);
                  beats_q  <= CNT_W'(burst_len(words_d));
                  state_q  <= (words_d == 17'd0) ? DONE : BURST;
               end
            end
            BURST: begin
               if (accept) begin
                  words_q <= words_q - 17'd1;
                  if (last_beat) begin
                     beats_q <= beats_q - CNT_W'(1);
                     state_q <= DONE;
                  end else if (beats_q == CNT_W'(1)) begin
                     // Back-to-back: next burst is set up for the following cycle.
                     addr_q  <= addr_q + {14'd0, bcnt_q, 2'b00};
                     bcnt_q  <= burst_len(words_q - 17'd1);
                     beats_q <= CNT_W'(burst_len(words_q - 17'd1));
                  end else begin
                     beats_q <= beats_q - CNT_W'(1);
                  end
               end
            end
            DONE: begin
               rdy_q   <= 1'b1;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wr_ctrl.sv
// Bench for wr_ctrl: directed transfers plus randomized FIFO gaps, stalls and
// spurious start requests, checked beat by beat against a transfer model.
module tb_wr_ctrl;
   localparam int MAX = 16;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;

   wr_ctrl_if bus ();

   wr_ctrl #(.MAX_BURST(MAX)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // One transfer. abort_at >= 0 pulls reset at that word index; gap_at/stall_at
   // force a 10-cycle empty gap / 3-cycle waitrequest at that word index.
   task automatic do_xfer(input logic [31:0] b, input logic [31:0] e,
                          input int empty_pct, input int wait_pct,
                          input int gap_at, input int stall_at,
                          input int abort_at, input bit tight);
      logic [31:0] ba;
      logic [15:0] len;
      logic [31:0] data[$];
      logic [31:0] exp_addr;
      logic [3:0]  exp_be;
      int words, idx, since_end, cyc, pops, last_acc, gap_cnt, stall_cnt, burst_no, exp_bc;
      bit exp_w;
      ba = {b[31:2], 2'b00};
      len = 16'(e - ba);
      words = (int'(len) + 3) / 4;
      data.delete();
      for (int i = 0; i < words; i++) data.push_back($urandom);

      @(negedge clk);
      bus.wr_ctrl = 1'b1; bus.dst_begin = b; bus.dst_end = e;
      bus.fifo_empty = 1'b1; bus.waitrequest = 1'b0;
      #1 check("idle_write", 32'(bus.write), 32'd0);

      since_end = (words == 0) ? 0 : -1;
      idx = 0; cyc = 0; pops = 0; last_acc = 0; gap_cnt = 0; stall_cnt = 0;
      while (since_end < 2 && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         if (since_end >= 0) since_end++;
         if (abort_at >= 0 && idx == abort_at) begin
            bus.fifo_empty = 1'b0; bus.fifo_out = data[idx]; bus.waitrequest = 1'b0;
            bus.wr_ctrl = 1'b0;
            reset = 1'b0;
            #1;
            check("rst_write", 32'(bus.write), 32'd0);
            check("rst_rd", 32'(bus.rd_from_fifo), 32'd0);
            check("rst_rdy", 32'(bus.wr_ctrl_rdy), 32'd0);
            check("rst_addr", bus.address, 32'd0);
            check("rst_bc", 32'(bus.burstcount), 32'd0);
            check("rst_be", 32'(bus.byteenable), 32'hF);
            repeat (3) begin
               @(negedge clk);
               #1;
               check("abort_write", 32'(bus.write), 32'd0);
               check("abort_rdy", 32'(bus.wr_ctrl_rdy), 32'd0);
            end
            reset = 1'b1;
            return;
         end
         bus.wr_ctrl = (since_end < 2) && ($urandom_range(7) == 0);
         bus.dst_begin = $urandom; bus.dst_end = $urandom;
         if (idx < words && idx == gap_at && gap_cnt < 10) begin
            gap_cnt++;
            bus.fifo_empty = 1'b1;
         end else begin
            bus.fifo_empty = (idx >= words) || (int'($urandom_range(99)) < empty_pct);
         end
         bus.fifo_out = bus.fifo_empty ? $urandom : data[idx];
         if (idx < words && idx == stall_at && stall_cnt < 3 && !bus.fifo_empty) begin
            stall_cnt++;
            bus.waitrequest = 1'b1;
         end else begin
            bus.waitrequest = (int'($urandom_range(99)) < wait_pct);
         end
         #1;
         exp_w = (since_end < 0) && !bus.fifo_empty;
         check("write", 32'(bus.write), 32'(exp_w));
         check("rd_from_fifo", 32'(bus.rd_from_fifo), 32'(exp_w && !bus.waitrequest));
         check("writedata", bus.writedata, bus.fifo_out);
         if (since_end < 0) begin
            burst_no = idx / MAX;
            exp_addr = ba + 32'(4 * MAX * burst_no);
            exp_bc = (words - burst_no * MAX > MAX) ? MAX : words - burst_no * MAX;
            exp_be = (idx == words - 1 && len[1:0] != 2'd0) ? 4'((1 << len[1:0]) - 1) : 4'hF;
            check("address", bus.address, exp_addr);
            check("burstcount", 32'(bus.burstcount), 32'(exp_bc));
            check("byteenable", 32'(bus.byteenable), 32'(exp_be));
         end
         check("wr_ctrl_rdy", 32'(bus.wr_ctrl_rdy), 32'(since_end == 2));
         if (exp_w && !bus.waitrequest) begin
            pops++;
            idx++;
            last_acc = cyc;
            if (idx == words) since_end = 0;
         end
      end
      bus.wr_ctrl = 1'b0;
      check("completed_in_budget", 32'(since_end == 2), 32'd1);
      check("pop_count", 32'(pops), 32'(words));
      if (tight) check("consecutive_beats", 32'(last_acc), 32'(words));
   endtask

   initial begin
      logic [31:0] rb;
      reset = 1'b0;
      bus.wr_ctrl = 1'b0; bus.dst_begin = '0; bus.dst_end = '0;
      bus.fifo_out = '0; bus.fifo_empty = 1'b1; bus.waitrequest = 1'b0;
      #1;
      check("reset_write", 32'(bus.write), 32'd0);
      check("reset_rd", 32'(bus.rd_from_fifo), 32'd0);
      check("reset_rdy", 32'(bus.wr_ctrl_rdy), 32'd0);
      check("reset_addr", bus.address, 32'd0);
      check("reset_bc", 32'(bus.burstcount), 32'd0);
      check("reset_be", 32'(bus.byteenable), 32'hF);
      repeat (2) @(negedge clk);
      reset = 1'b1;

      // Single full burst, no stalls.
      do_xfer(32'h1000, 32'h1040, 0, 0, -1, -1, -1, 1'b1);
      // 34 words in bursts 16/16/2 with partial final word.
      do_xfer(32'h2000, 32'h2086, 0, 0, -1, -1, -1, 1'b1);
      // Stall on beat 2 for 3 cycles.
      do_xfer(32'h100, 32'h110, 0, 0, -1, 1, -1, 1'b0);
      // FIFO gap after 5 of 8 words.
      do_xfer(32'h300, 32'h320, 0, 0, 5, -1, -1, 1'b0);
      // Zero-length transfer.
      do_xfer(32'h40, 32'h40, 0, 0, -1, -1, -1, 1'b0);
      // Reset at beat 7 of 16, then a fresh 4-word transfer.
      do_xfer(32'h1000, 32'h1040, 0, 0, -1, -1, 6, 1'b0);
      do_xfer(32'h500, 32'h510, 0, 0, -1, -1, -1, 1'b1);
      // Wrapped range: modular 16-bit length of 16 bytes.
      do_xfer(32'h0001_0000, 32'h0000_0010, 10, 10, -1, -1, -1, 1'b0);
      // Unaligned start address bits are ignored.
      do_xfer(32'h603, 32'h60B, 0, 0, -1, -1, -1, 1'b1);

      for (int t = 0; t < 12; t++) begin
         rb = {$urandom_range(32'h0FFF_FFFF), 2'b00};
         do_xfer(rb, rb + 32'($urandom_range(400)),
                 int'($urandom_range(50)), int'($urandom_range(50)),
                 -1, -1, -1, 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
